// File: rtl/jtag_cmd_seq.sv
// JTAG command sequencer: turns RESET / TMS_SEQ / SCAN / SCAN_FLIP_TMS commands into tck/tms/tdi bit streams.
// Optional tck rising-edge counter output enabled by defining JTAG_CMD_SEQ_CNT_EN.
module jtag_cmd_seq #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_nbits_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i,
  output logic        busy_o
`ifdef JTAG_CMD_SEQ_CNT_EN
  ,
  output logic [15:0] tck_count_o
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] SHIFT_LO = 3'd2;
  localparam logic [2:0] SHIFT_HI = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_TMS   = 2'd1;
  localparam logic [1:0] OP_SCAN  = 2'd2;

  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  last_q, last_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic [31:0] rsp_q, rsp_d;
  logic        alive_q;
  logic        div_end;

  // TMS/TDI value for bit idx of the captured command
  function automatic logic bit_tms(input logic [1:0] op, input logic [4:0] idx,
                                   input logic [4:0] last, input logic [31:0] data);
    case (op)
      OP_RESET: bit_tms = (idx < 5'd5);
      OP_TMS:   bit_tms = data[idx];
      OP_SCAN:  bit_tms = 1'b0;
      default:  bit_tms = (idx == last);
    endcase
  endfunction

  function automatic logic bit_tdi(input logic [1:0] op, input logic [4:0] idx,
                                   input logic [31:0] data);
    bit_tdi = op[1] ? data[idx] : 1'b0;
  endfunction

  assign div_end     = (div_q == DIV_LAST);
  assign cmd_ready_o = alive_q && (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    last_d  = last_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d    = cmd_op_i;
          last_d  = (cmd_op_i == OP_RESET) ? 5'd5 : cmd_nbits_i;
          data_d  = cmd_data_i;
          rsp_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tms_d   = bit_tms(op_q, 5'd0, last_q, data_q);
        tdi_d   = bit_tdi(op_q, 5'd0, data_q);
        cnt_d   = '0;
        div_d   = '0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (div_end) begin
          div_d        = '0;
          tck_d        = 1'b1;
          rsp_d[cnt_q] = tdo_i;
          state_d      = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        // falling tck edge: either launch the next bit or park the lines at zero
        if (div_end) begin
          div_d = '0;
          tck_d = 1'b0;
          if (cnt_q == last_q) begin
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            state_d = op_q[1] ? RESP : IDLE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            tms_d   = bit_tms(op_q, cnt_q + 5'd1, last_q, data_q);
            tdi_d   = bit_tdi(op_q, cnt_q + 5'd1, data_q);
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      last_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b0;
      tdi_q   <= 1'b0;
      rsp_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      last_q  <= last_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      rsp_q   <= rsp_d;
      alive_q <= 1'b1;
    end
  end

`ifdef JTAG_CMD_SEQ_CNT_EN
  logic [15:0] tck_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_count_q <= '0;
    end else if (state_q == SHIFT_LO && div_end) begin
      tck_count_q <= tck_count_q + 16'd1;
    end
  end

  assign tck_count_o = tck_count_q;
`endif

endmodule

// File: tb/tb_jtag_cmd_seq.sv
// Self-checking bench for jtag_cmd_seq: random and directed commands against a spec-level model of the bit streams.
// Runs with TCK_DIV = 2 and tdo looped back to tdi (optionally inverted or forced high).
module tb_jtag_cmd_seq;
  localparam int DIV   = 2;
  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_nbits = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, tdo;
  logic        busy;
  logic        tdoInv = 1'b0;
  logic        tdoForce = 1'b0;
`ifdef JTAG_CMD_SEQ_CNT_EN
  logic [15:0] tck_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int posCycle = 0;

  jtag_cmd_seq #(.TCK_DIV(DIV)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_nbits_i (cmd_nbits),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .tck_o       (tck),
    .tms_o       (tms),
    .tdi_o       (tdi),
    .tdo_i       (tdo),
    .busy_o      (busy)
`ifdef JTAG_CMD_SEQ_CNT_EN
    ,
    .tck_count_o (tck_count)
`endif
  );

  assign tdo = tdoForce ? 1'b1 : (tdi ^ tdoInv);

  always #5 clk = ~clk;

  always @(posedge clk) posCycle <= posCycle + 1;

  // Pulse monitor: records tms/tdi at each tck rise and checks phase widths and line stability
  logic        tckPrev = 1'b0;
  logic        heldTms = 1'b0, heldTdi = 1'b0;
  logic [63:0] obsTms = '0, obsTdi = '0;
  int          obsN = 0, firstRise = -1, highLen = 0, lowLen = 0;
  int          widthErr = 0, holdErr = 0;
  bit          rspSeen = 1'b0;

  always @(negedge clk) begin
    if (tck && !tckPrev) begin
      if (obsN < 64) begin
        obsTms[obsN] = tms;
        obsTdi[obsN] = tdi;
      end
      if (obsN == 0) firstRise = posCycle;
      else if (lowLen != DIV) widthErr++;
      obsN++;
      highLen = 1;
      heldTms = tms;
      heldTdi = tdi;
    end else if (tck) begin
      highLen++;
      if (tms !== heldTms || tdi !== heldTdi) holdErr++;
    end else if (tckPrev) begin
      if (highLen != DIV) widthErr++;
      lowLen = 1;
    end else begin
      lowLen++;
    end
    if (rsp_valid) rspSeen = 1'b1;
    tckPrev = tck;
  end

  // Spec-level expectation for one command
  function automatic void model(input logic [1:0] op, input logic [4:0] nb, input logic [31:0] d,
                                input bit inv, input bit force1, output int n,
                                output logic [63:0] eTms, output logic [63:0] eTdi,
                                output logic [31:0] eRsp);
    n    = (op == 2'd0) ? 6 : int'(nb) + 1;
    eTms = '0;
    eTdi = '0;
    eRsp = '0;
    for (int i = 0; i < n; i++) begin
      case (op)
        2'd0:    eTms[i] = (i < 5);
        2'd1:    eTms[i] = d[i];
        2'd2:    eTms[i] = 1'b0;
        default: eTms[i] = (i == n - 1);
      endcase
      if (op >= 2'd2) begin
        eTdi[i] = d[i];
        eRsp[i] = force1 ? 1'b1 : (d[i] ^ inv);
      end
    end
  endfunction

  task automatic clear_monitor();
    obsN = 0; obsTms = '0; obsTdi = '0; rspSeen = 1'b0;
    widthErr = 0; holdErr = 0; firstRise = -1; lowLen = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] nb, input logic [31:0] d,
                       output int acc);
    int t = 0;
    while (!cmd_ready && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
    end
    clear_monitor();
    cmd_op = op; cmd_nbits = nb; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    acc = posCycle;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit scan, output bit to);
    int t = 0;
    while (!(scan ? rsp_valid : cmd_ready) && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
    end
    to = (t >= LIMIT);
    @(negedge clk); #1;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({tck, tms, tdi, rsp_valid, busy, cmd_ready} !== 6'b0 || rsp_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b/%h expected 000000/00000000",
               {tck, tms, tdi, rsp_valid, busy, cmd_ready}, rsp_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", cmd_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ready_after_edge: got ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

`ifdef JTAG_CMD_SEQ_CNT_EN
  task automatic test_tck_count();
    int acc;
    bit to;
    vectors++;
    if (tck_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL tck_count_reset: got %0d expected 0", tck_count);
    end
    issue(2'd0, 5'd0, 32'h0, acc);
    wait_done(1'b0, to);
    issue(2'd2, 5'd31, $urandom(), acc);
    wait_done(1'b1, to);
    release_rsp();
    vectors++;
    if (tck_count !== 16'd38) begin
      miscompares++;
      $display("[TB] FAIL tck_count_38: got %0d expected 38", tck_count);
    end
  endtask
`endif

  task automatic test_scan_loopback();
    int acc;
    bit to;
    issue(2'd2, 5'd7, 32'h0000_00A5, acc);
    wait_done(1'b1, to);
    vectors++;
    if (to || rsp_data !== 32'h0000_00A5) begin
      miscompares++;
      $display("[TB] FAIL scan_a5_rsp: got %h (timeout=%0d) expected 000000a5", rsp_data, to);
    end
    vectors++;
    if (obsN != 8 || obsTms !== 64'h0 || obsTdi !== 64'hA5 || widthErr != 0 || holdErr != 0) begin
      miscompares++;
      $display("[TB] FAIL scan_a5_pulses: got n=%0d tms=%h tdi=%h werr=%0d herr=%0d expected 8/0/a5/0/0",
               obsN, obsTms, obsTdi, widthErr, holdErr);
    end
    vectors++;
    if (firstRise - acc != 1 + DIV) begin
      miscompares++;
      $display("[TB] FAIL scan_latency: got %0d expected %0d", firstRise - acc, 1 + DIV);
    end
    release_rsp();
    vectors++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL scan_release: got ready=%b valid=%b expected 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_op();
    int acc;
    bit to;
    issue(2'd0, 5'($urandom_range(0, 31)), $urandom(), acc);
    wait_done(1'b0, to);
    vectors++;
    if (to || obsN != 6 || obsTms !== 64'h1F || obsTdi !== 64'h0 || rspSeen) begin
      miscompares++;
      $display("[TB] FAIL reset_op: got to=%0d n=%0d tms=%h tdi=%h rsp=%0d expected 0/6/1f/0/0",
               to, obsN, obsTms, obsTdi, rspSeen);
    end
    vectors++;
    if ({tck, tms, tdi, busy, cmd_ready} !== 5'b00001) begin
      miscompares++;
      $display("[TB] FAIL reset_op_idle: got %b expected 00001", {tck, tms, tdi, busy, cmd_ready});
    end
  endtask

  task automatic test_flip();
    int acc;
    bit to;
    tdoForce = 1'b1;
    issue(2'd3, 5'd3, 32'h9, acc);
    wait_done(1'b1, to);
    vectors++;
    if (to || rsp_data !== 32'h0000_000F || obsN != 4 || obsTms !== 64'h8 || obsTdi !== 64'h9) begin
      miscompares++;
      $display("[TB] FAIL flip_tms: got to=%0d rsp=%h n=%0d tms=%h tdi=%h expected 0/0000000f/4/8/9",
               to, rsp_data, obsN, obsTms, obsTdi);
    end
    release_rsp();
    tdoForce = 1'b0;
  endtask

  task automatic test_rsp_hold();
    int acc, n;
    bit to;
    logic [4:0]  nb = 5'($urandom_range(0, 31));
    logic [31:0] d = $urandom();
    logic [63:0] eTms, eTdi;
    logic [31:0] eRsp;
    tdoInv = 1'b1;
    model(2'd2, nb, d, 1'b1, 1'b0, n, eTms, eTdi, eRsp);
    issue(2'd2, nb, d, acc);
    wait_done(1'b1, to);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== eRsp || cmd_ready !== 1'b0 || tck !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rsp_hold[%0d]: got v=%b d=%h r=%b tck=%b expected 1/%h/0/0",
                 c, rsp_valid, rsp_data, cmd_ready, tck, eRsp);
      end
    end
    release_rsp();
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rsp_hold_exit: got v=%b r=%b busy=%b expected 0/1/0", rsp_valid, cmd_ready, busy);
    end
    tdoInv = 1'b0;
  endtask

  task automatic test_midreset();
    int acc, t, n;
    bit to;
    logic [4:0]  nb;
    logic [31:0] d;
    logic [63:0] eTms, eTdi;
    logic [31:0] eRsp;
    issue(2'd2, 5'd31, $urandom(), acc);
    t = 0;
    while (obsN < 6 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (t >= LIMIT || {tck, tms, tdi, rsp_valid, busy, cmd_ready} !== 6'b0 || rsp_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_zero: got %b/%h (timeout=%0d) expected 000000/00000000",
               {tck, tms, tdi, rsp_valid, busy, cmd_ready}, rsp_data, t >= LIMIT);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (rspSeen || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_rsp: got rsp_seen=%0d busy=%b expected 0/0", rspSeen, busy);
    end
    nb = 5'($urandom_range(0, 31));
    d  = $urandom();
    model(2'd2, nb, d, 1'b0, 1'b0, n, eTms, eTdi, eRsp);
    issue(2'd2, nb, d, acc);
    wait_done(1'b1, to);
    vectors++;
    if (to || rsp_data !== eRsp || obsN != n || obsTdi !== eTdi || obsTms !== eTms) begin
      miscompares++;
      $display("[TB] FAIL midreset_next: got to=%0d rsp=%h n=%0d expected 0/%h/%0d", to, rsp_data, obsN, eRsp, n);
    end
    release_rsp();
  endtask

  task automatic test_nbits_bounds();
    int acc, n;
    bit to;
    logic [31:0] d;
    logic [63:0] eTms, eTdi;
    logic [31:0] eRsp;
    for (int k = 0; k < 2; k++) begin
      d = $urandom();
      model(2'd2, (k == 0) ? 5'd0 : 5'd31, d, 1'b0, 1'b0, n, eTms, eTdi, eRsp);
      issue(2'd2, (k == 0) ? 5'd0 : 5'd31, d, acc);
      wait_done(1'b1, to);
      vectors++;
      if (to || rsp_data !== eRsp || obsN != n || obsTdi !== eTdi || widthErr != 0) begin
        miscompares++;
        $display("[TB] FAIL nbits_bound[%0d]: got to=%0d rsp=%h n=%0d werr=%0d expected 0/%h/%0d/0",
                 k, to, rsp_data, obsN, widthErr, eRsp, n);
      end
      release_rsp();
    end
  endtask

  task automatic test_back_to_back();
    int accA, accB, t, nA, nB;
    bit to;
    logic [4:0]  nbA = 5'($urandom_range(0, 15));
    logic [31:0] dA = $urandom();
    logic [4:0]  nbB = 5'($urandom_range(0, 31));
    logic [31:0] dB = $urandom();
    logic [63:0] eTmsA, eTdiA, eTmsB, eTdiB;
    logic [31:0] eRspA, eRspB;
    model(2'd1, nbA, dA, 1'b0, 1'b0, nA, eTmsA, eTdiA, eRspA);
    model(2'd2, nbB, dB, 1'b0, 1'b0, nB, eTmsB, eTdiB, eRspB);
    issue(2'd1, nbA, dA, accA);
    cmd_op = 2'd2; cmd_nbits = nbB; cmd_data = dB; cmd_valid = 1'b1;
    t = 0;
    while (busy !== 1'b0 && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
    end
    while (busy !== 1'b1 && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
    end
    accB = posCycle;
    cmd_valid = 1'b0;
    vectors++;
    if (t >= LIMIT || accB - accA != 2 + 2 * DIV * nA) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept_gap: got %0d expected %0d", accB - accA, 2 + 2 * DIV * nA);
    end
    vectors++;
    if (obsN != nA || obsTms !== eTmsA || obsTdi !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL b2b_tms_seq: got n=%0d tms=%h tdi=%h expected %0d/%h/0", obsN, obsTms, obsTdi, nA, eTmsA);
    end
    clear_monitor();
    wait_done(1'b1, to);
    vectors++;
    if (to || rsp_data !== eRspB || obsN != nB || obsTdi !== eTdiB || firstRise - accB != 1 + DIV) begin
      miscompares++;
      $display("[TB] FAIL b2b_scan: got to=%0d rsp=%h n=%0d lat=%0d expected 0/%h/%0d/%0d",
               to, rsp_data, obsN, firstRise - accB, eRspB, nB, 1 + DIV);
    end
    release_rsp();
  endtask

  task automatic test_random();
    int acc, n;
    bit to;
    logic [1:0]  op;
    logic [4:0]  nb;
    logic [31:0] d;
    logic [63:0] eTms, eTdi;
    logic [31:0] eRsp;
    for (int k = 0; k < 12; k++) begin
      op = 2'($urandom_range(0, 3));
      nb = 5'($urandom_range(0, 31));
      d  = $urandom();
      tdoInv = 1'($urandom_range(0, 1));
      model(op, nb, d, tdoInv, 1'b0, n, eTms, eTdi, eRsp);
      issue(op, nb, d, acc);
      wait_done(op[1], to);
      vectors++;
      if (to || obsN != n || obsTms !== eTms || obsTdi !== eTdi || widthErr != 0 || holdErr != 0
          || firstRise - acc != 1 + DIV) begin
        miscompares++;
        $display("[TB] FAIL rand_stream[%0d] op=%0d: got to=%0d n=%0d tms=%h tdi=%h werr=%0d herr=%0d expected n=%0d tms=%h tdi=%h",
                 k, op, to, obsN, obsTms, obsTdi, widthErr, holdErr, n, eTms, eTdi);
      end
      vectors++;
      if (op[1] ? (rsp_data !== eRsp) : (rspSeen || cmd_ready !== 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL rand_rsp[%0d] op=%0d: got rsp=%h seen=%0d ready=%b expected %h",
                 k, op, rsp_data, rspSeen, cmd_ready, eRsp);
      end
      if (op[1]) release_rsp();
    end
    tdoInv = 1'b0;
  endtask

  initial begin
    $display("[TB] start, TCK_DIV=%0d", DIV);
    test_reset();
`ifdef JTAG_CMD_SEQ_CNT_EN
    test_tck_count();
`endif
    test_scan_loopback();
    test_reset_op();
    test_flip();
    test_rsp_hold();
    test_nbits_bounds();
    test_back_to_back();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
